// File: rtl/uart_echo_pkg.sv
// uart_echo_pkg: shared FSM state encoding and transform mode constants for the UART echo bridge.
package uart_echo_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, SEND, WAIT} state_e;
  localparam logic [1:0] MODE_PASS   = 2'd0;
  localparam logic [1:0] MODE_ADD    = 2'd1;
  localparam logic [1:0] MODE_INV    = 2'd2;
  localparam logic [1:0] MODE_BITREV = 2'd3;
endpackage

// File: rtl/uart_echo_fifo.sv
// uart_echo_fifo: synchronous DW x DEPTH FIFO; pushes when full and pops when empty are ignored.
module uart_echo_fifo #(
  parameter int DW    = 8,
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [DW-1:0] wdata_i,
  output logic [DW-1:0] rdata_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [CW-1:0] count_o
);
  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [CW-1:0] count_q;
  logic          do_push, do_pop;
  assign full_o  = count_q == CW'(DEPTH);
  assign empty_o = count_q == '0;
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_q];
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  always_ff @(posedge clk)
    if (do_push) mem_q[wr_q] <= wdata_i;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + AW'(1);
      if (do_pop) rd_q <= rd_q + AW'(1);
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
endmodule

// File: rtl/uart_echo_bridge.sv
// uart_echo_bridge: buffers received UART frames and echoes them to TX through a mode-selected transform.
// Define UART_ECHO_ERR_DROP_EN to discard frames flagged with rx_error instead of echoing them.
module uart_echo_bridge
  import uart_echo_pkg::*;
#(
  parameter int DW          = 8,
  parameter int DEPTH       = 16,
  parameter int INC         = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rx_ready,
  input  logic [DW-1:0]          rx_data,
  input  logic                   rx_error,
  input  logic                   tx_ready,
  input  logic [1:0]             mode,
  output logic [DW-1:0]          tx_data,
  output logic                   tx_send,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   overflow
);
  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] rx_sync_q, tx_sync_q;
  logic                   rx_prev_q, overflow_q;
  logic [DW-1:0]          tx_data_q, tx_data_d, head, rev, xf;
  logic                   rise, push, pop, full, empty, tx_ready_s;
  assign tx_ready_s = tx_sync_q[SYNC_STAGES-1];
  assign rise       = rx_sync_q[SYNC_STAGES-1] & ~rx_prev_q;
`ifdef UART_ECHO_ERR_DROP_EN
  assign push = rise & ~rx_error;
`else
  logic unused_rx_error;
  assign unused_rx_error = rx_error;
  assign push = rise;
`endif
  assign pop      = state_q == LOAD;
  assign tx_send  = state_q == SEND;
  assign tx_data  = tx_data_q;
  assign overflow = overflow_q;
  uart_echo_fifo #(.DW(DW), .DEPTH(DEPTH)) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .push_i (push),
    .pop_i  (pop),
    .wdata_i(rx_data),
    .rdata_o(head),
    .full_o (full),
    .empty_o(empty),
    .count_o(fifo_count)
  );
  always_comb begin
    rev = '0;
    for (int i = 0; i < DW; i++) rev[i] = head[DW-1-i];
    xf = mode == MODE_ADD    ? head + DW'(INC) :
         mode == MODE_INV    ? ~head :
         mode == MODE_BITREV ? rev : head;
  end
  always_comb begin
    state_d   = state_q;
    tx_data_d = tx_data_q;
    unique case (state_q)
      IDLE: if (!empty && tx_ready_s) state_d = LOAD;
      LOAD: begin
        tx_data_d = xf;
        state_d   = SEND;
      end
      SEND: if (!tx_ready_s) state_d = WAIT;
      WAIT: if (tx_ready_s) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q    <= IDLE;
      tx_data_q  <= '0;
      rx_sync_q  <= '0;
      tx_sync_q  <= '0;
      rx_prev_q  <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      tx_data_q  <= tx_data_d;
      rx_sync_q  <= {rx_sync_q[SYNC_STAGES-2:0], rx_ready};
      tx_sync_q  <= {tx_sync_q[SYNC_STAGES-2:0], tx_ready};
      rx_prev_q  <= rx_sync_q[SYNC_STAGES-1];
      if (push && full) overflow_q <= 1'b1;
    end
endmodule
